lander_display: RTL

//  Display formatter downstream of the lunar-lander core. Takes the core's 4-digit BCD state
//  (altitude, velocity, fuel) and its thrust digit, and drives the eight 7-segment digits.
//  - User picks the shown quantity with mode keys.
//  - Leading zeros are blanked; a minus sign is shown for negative velocity.
//  - Crash and land status are indicated on the display.

---
 rtl/lander_pkg.sv | 33 +++
 rtl/bcd_tencomp4.sv | 25 ++
 rtl/ssdec.sv | 27 ++
 rtl/lander_display.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lander_pkg.sv
// Shared types and segment constants for the lunar-lander display formatter.
package lander_pkg;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_VEL    = 2'd1,
    MODE_FUEL   = 2'd2,
    MODE_THRUST = 2'd3
  } disp_mode_t;

  // Segment patterns are gfedcba, dp is added by the formatter.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_T     = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b1111111;

  function automatic logic [6:0] modeLetter(input disp_mode_t m);
    logic [6:0] letter;
    letter = SEG_BLANK;
    case (m)
      MODE_ALT:    letter = SEG_A;
      MODE_VEL:    letter = SEG_U;
      MODE_FUEL:   letter = SEG_F;
      MODE_THRUST: letter = SEG_T;
      default:     letter = SEG_BLANK;
    endcase
    return letter;
  endfunction

endpackage

// File: rtl/bcd_tencomp4.sv
// Combinational 4-digit BCD 10's complement: per-digit 9's complement plus one.
module bcd_tencomp4 (
  input  logic [15:0] value_i,
  output logic [15:0] comp_o
);

  always_comb begin
    logic       carry;
    logic [3:0] nine;
    carry  = 1'b1;
    nine   = 4'd0;
    comp_o = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      nine = 4'd9 - value_i[4*i +: 4];
      // A 9 that receives the carry rolls to 0 and passes the carry upward.
      if (carry && (nine == 4'd9)) begin
        comp_o[4*i +: 4] = 4'd0;
      end else begin
        comp_o[4*i +: 4] = nine + {3'b000, carry};
        carry = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ssdec.sv
// BCD to 7-segment decoder (gfedcba), dark when disabled or fed a non-BCD code.
module ssdec (
  input  logic [3:0] bcd_i,
  input  logic       en_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    if (en_i) begin
      case (bcd_i)
        4'd0:    seg_o = 7'b0111111;
        4'd1:    seg_o = 7'b0000110;
        4'd2:    seg_o = 7'b1011011;
        4'd3:    seg_o = 7'b1001111;
        4'd4:    seg_o = 7'b1100110;
        4'd5:    seg_o = 7'b1101101;
        4'd6:    seg_o = 7'b1111101;
        4'd7:    seg_o = 7'b0000111;
        4'd8:    seg_o = 7'b1111111;
        4'd9:    seg_o = 7'b1100111;
        default: seg_o = 7'b0000000;
      endcase
    end
  end

endmodule

// File: rtl/lander_display.sv
// Eight-digit 7-segment formatter for the lander core: mode keys, blanking, sign, land/crash.
// Define LANDER_DISPLAY_BLINK_EN to blink the value digits on crash instead of showing "8888".
module lander_display
  import lander_pkg::*;
#(
  parameter int BLINK_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  key,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [3:0]  thrust,
  input  logic        crash,
  input  logic        land,
  output logic [63:0] ss,
  output logic [1:0]  mode
);

  logic [3:0]  keySync1_q, keySync2_q, keyPrev_q, keyRise;
  disp_mode_t  mode_q, mode_d;
  logic [63:0] ss_q, ss_d;
  logic [15:0] velComp, value;
  logic        negative, dp;
  logic [3:0]  digitLit;
  logic [6:0]  digitSeg [4];
  logic [6:0]  valueSeg [4];

  assign keyRise = keySync2_q & ~keyPrev_q;

  // Lowest-index rising edge wins when several keys rise together.
  always_comb begin
    mode_d = mode_q;
    if (keyRise[0])      mode_d = MODE_ALT;
    else if (keyRise[1]) mode_d = MODE_VEL;
    else if (keyRise[2]) mode_d = MODE_FUEL;
    else if (keyRise[3]) mode_d = MODE_THRUST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keySync1_q <= 4'b0000;
      keySync2_q <= 4'b0000;
      keyPrev_q  <= 4'b0000;
      mode_q     <= MODE_ALT;
      ss_q       <= 64'h0;
    end else begin
      keySync1_q <= key;
      keySync2_q <= keySync1_q;
      keyPrev_q  <= keySync2_q;
      mode_q     <= mode_d;
      ss_q       <= ss_d;
    end
  end

  bcd_tencomp4 uVelComp (
    .value_i (vel),
    .comp_o  (velComp)
  );

  always_comb begin
    negative = 1'b0;
    value    = alt;
    case (mode_q)
      MODE_ALT:    value = alt;
      MODE_VEL: begin
        negative = (vel[15:12] >= 4'd5);
        value    = negative ? velComp : vel;
      end
      MODE_FUEL:   value = fuel;
      MODE_THRUST: value = {12'h000, thrust};
      default:     value = alt;
    endcase
  end

  assign digitLit[3] = |value[15:12];
  assign digitLit[2] = digitLit[3] | (|value[11:8]);
  assign digitLit[1] = digitLit[2] | (|value[7:4]);
  assign digitLit[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : gDigit
    ssdec uDec (
      .bcd_i (value[4*i +: 4]),
      .en_i  (digitLit[i]),
      .seg_o (digitSeg[i])
    );
  end

`ifdef LANDER_DISPLAY_BLINK_EN
  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CNT_W-1:0] blinkCnt_q;
  logic             blinkPhase_q;

  // Blink timing only runs while crashed; leaving crash restores visible digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (!crash) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (tick) begin
      if (blinkCnt_q == CNT_W'(BLINK_TICKS - 1)) begin
        blinkCnt_q   <= '0;
        blinkPhase_q <= ~blinkPhase_q;
      end else begin
        blinkCnt_q <= blinkCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valueSeg[i] = (crash && blinkPhase_q) ? SEG_BLANK : digitSeg[i];
    end
  end
`else
  // Without blinking, tick and the blink period have nothing to drive.
  logic unusedTick;
  localparam int unusedBlinkTicks = BLINK_TICKS;
  assign unusedTick = tick;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valueSeg[i] = crash ? SEG_EIGHT : digitSeg[i];
    end
  end
`endif

  assign dp = land & ~crash;

  always_comb begin
    ss_d = {dp, modeLetter(mode_q),
            dp, SEG_BLANK,
            dp, (negative ? SEG_MINUS : SEG_BLANK),
            dp, SEG_BLANK,
            dp, valueSeg[3],
            dp, valueSeg[2],
            dp, valueSeg[1],
            dp, valueSeg[0]};
  end

  assign ss   = ss_q;
  assign mode = mode_q;

endmodule
